// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//
// Memory-mapped eight-digit seven-segment display controller. A 32-bit value
// is held as eight hex nibbles and time-multiplexed onto the digits by a
// refresh prescaler. The value and the digit-enable mask are double-buffered:
// the scan reads shadow copies that are reloaded only at a frame boundary
// (the digit index wrapping to 0) or on a FORCE_LOAD write. A frame therefore
// never shows a half-updated value.
//
// Register map (word offset on addr):
//   0 VALUE  (RW) nibble k is shown on digit k
//   1 MASK   (RW) bits [7:0] enable digits, bits [31:8] read 0
//   2 CTRL   bit0 BLANK (RW), bit1 FORCE_LOAD (write 1 to load shadows, reads 0)
//   3 STATUS (RO) bits [2:0] current digit index
//
// Ports:
//   clk     system clock
//   rst     asynchronous active-low reset
//   sel     bus request, held by the master until ready
//   we      1 = write, 0 = read (qualified by sel)
//   addr    word offset
//   wdata   write data
//   rdata   read data, valid while ready=1, otherwise 0
//   ready   one-cycle completion pulse, the cycle after acceptance
//   an      digit anodes, active-low
//   a_to_g  segments {a,b,c,d,e,f,g}, active-low
//
// Optional feature (compile-time macro SEG7_LEADING_ZERO_BLANK_EN):
//   when defined, a digit whose shadow nibble is 0 is turned off if all
//   higher nibbles (up to NUM_DIGITS-1) are also 0. Digit 0 is never
//   suppressed. When undefined, all masked-in digits are shown.
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000,  // clk cycles per digit slot, >= 2
  parameter int NUM_DIGITS  = 8        // digits scanned, 1..8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [7:0]  an,
  output logic [6:0]  a_to_g
);

  localparam int             PW        = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0]  PRESC_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [2:0]     IDX_MAX   = 3'(NUM_DIGITS - 1);

  localparam logic [1:0] ADDR_VALUE  = 2'd0;
  localparam logic [1:0] ADDR_MASK   = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   value_q, value_d;
  logic [7:0]    mask_q, mask_d;
  logic          blank_q, blank_d;
  logic [31:0]   shadow_val_q, shadow_val_d;
  logic [7:0]    shadow_mask_q, shadow_mask_d;
  logic          ready_q, ready_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    a_to_g_q, a_to_g_d;

  logic          tick;
  logic          frame_wrap;
  logic          accept;
  logic          wr_en;
  logic          force_load;
  logic [31:0]   read_word;
  logic [7:0]    digit_present;
  logic [7:0]    lz_suppress;
  logic [7:0]    digit_lit;
  logic [3:0]    cur_nibble;

  // Anodes at or above NUM_DIGITS are never driven low.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_present
      if (gi < NUM_DIGITS) begin : g_on
        assign digit_present[gi] = 1'b1;
      end else begin : g_off
        assign digit_present[gi] = 1'b0;
      end
    end
  endgenerate

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // Nibbles beyond the scanned digits are treated as zero, so "all higher
  // nibbles zero" is simply a zero test on the in-range bits above digit k.
  localparam logic [31:0] VAL_RANGE = (NUM_DIGITS >= 8) ? 32'hFFFF_FFFF
                                    : ((32'd1 << (4 * NUM_DIGITS)) - 32'd1);
  logic [31:0] val_in_range;
  assign val_in_range = shadow_val_q & VAL_RANGE;

  generate
    for (gi = 0; gi < 8; gi++) begin : g_lz
      if (gi == 0) begin : g_d0
        assign lz_suppress[gi] = 1'b0;
      end else begin : g_dk
        assign lz_suppress[gi] = (val_in_range[31:4*gi] == '0);
      end
    end
  endgenerate
`else
  assign lz_suppress = 8'h00;
`endif

  // Hex to active-low {a,b,c,d,e,f,g}.
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  assign tick       = (presc_q == PRESC_MAX);
  assign frame_wrap = tick && (idx_q == IDX_MAX);
  // A new request is taken only while no completion pulse is outstanding.
  assign accept     = sel && !ready_q;
  assign wr_en      = accept && we;
  assign force_load = wr_en && (addr == ADDR_CTRL) && wdata[1];

  always_comb begin
    read_word = 32'd0;
    case (addr)
      ADDR_VALUE:  read_word = value_q;
      ADDR_MASK:   read_word = {24'd0, mask_q};
      ADDR_CTRL:   read_word = {31'd0, blank_q};
      ADDR_STATUS: read_word = {29'd0, idx_q};
      default:     read_word = 32'd0;
    endcase
  end

  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;

    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_MAX) ? 3'd0 : idx_q + 3'd1;
    end

    value_d = value_q;
    mask_d  = mask_q;
    blank_d = blank_q;
    if (wr_en) begin
      case (addr)
        ADDR_VALUE: value_d = wdata;
        ADDR_MASK:  mask_d  = wdata[7:0];
        ADDR_CTRL:  blank_d = wdata[0];
        default:    ;  // STATUS is read-only
      endcase
    end

    // Shadows take the pre-write registers, so a VALUE write coinciding with
    // a load shows up one frame later.
    shadow_val_d  = shadow_val_q;
    shadow_mask_d = shadow_mask_q;
    if (frame_wrap || force_load) begin
      shadow_val_d  = value_q;
      shadow_mask_d = mask_q;
    end

    ready_d = accept;
    rdata_d = (accept && !we) ? read_word : 32'd0;
  end

  // Output stage: registered from the current index, one cycle behind it.
  // BLANK is deliberately live (not shadowed) so it acts on the next cycle.
  always_comb begin
    digit_lit  = (8'd1 << idx_q) & shadow_mask_q & digit_present
               & {8{~blank_q}} & ~lz_suppress;
    an_d       = ~digit_lit;
    cur_nibble = shadow_val_q[{idx_q, 2'b00} +: 4];
    a_to_g_d   = seg_decode(cur_nibble);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q       <= '0;
      idx_q         <= 3'd0;
      value_q       <= 32'd0;
      mask_q        <= 8'hFF;
      blank_q       <= 1'b0;
      shadow_val_q  <= 32'd0;
      shadow_mask_q <= 8'hFF;
      ready_q       <= 1'b0;
      rdata_q       <= 32'd0;
      an_q          <= 8'hFF;
      a_to_g_q      <= 7'h7F;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      value_q       <= value_d;
      mask_q        <= mask_d;
      blank_q       <= blank_d;
      shadow_val_q  <= shadow_val_d;
      shadow_mask_q <= shadow_mask_d;
      ready_q       <= ready_d;
      rdata_q       <= rdata_d;
      an_q          <= an_d;
      a_to_g_q      <= a_to_g_d;
    end
  end

  assign rdata  = rdata_q;
  assign ready  = ready_q;
  assign an     = an_q;
  assign a_to_g = a_to_g_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
//
// Directed bench for seg7_scan_driver with REFRESH_DIV=4, NUM_DIGITS=8.
// Register behaviour is covered by a table of bus transactions; scanning,
// double-buffering, blanking and reset are covered by hand-written sequences.
// "edges" counts clk edges since the last reset release, so a digit slot
// lasts 4 edges and a frame 32 edges.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        ready;
  logic [7:0]  an;
  logic [6:0]  a_to_g;

  int n_checks = 0;
  int n_fail   = 0;
  int edges;

  seg7_scan_driver #(.REFRESH_DIV(4), .NUM_DIGITS(8)) dut (
    .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .an(an), .a_to_g(a_to_g)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) edges <= 0;
    else      edges <= edges + 1;
  end

  typedef struct {
    logic        w;
    logic [1:0]  a;
    logic [31:0] d;
    logic        has_exp;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a negedge with ready low; returns two negedges later.
  task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d,
                     output logic [31:0] q);
    sel = 1'b1; we = w; addr = a; wdata = d;
    @(negedge clk);
    chk("ready_pulse", {31'd0, ready}, 32'd1);
    q = rdata;
    sel = 1'b0; we = 1'b0;
    @(negedge clk);
    chk("ready_drop", {31'd0, ready}, 32'd0);
    chk("rdata_idle", rdata, 32'd0);
    $display("bus %s addr=%0d wdata=%h rdata=%h", w ? "WR" : "RD", a, d, q);
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < 40; i++) begin
      if ((edges % 32) == p) break;
      @(negedge clk);
    end
    chk("phase_sync", edges % 32, p);
  endtask

  task automatic wait_digit(input int k, input logic [6:0] exp_seg);
    logic [7:0] target;
    target = ~(8'd1 << k);
    for (int i = 0; i < 80; i++) begin
      if (an === target) break;
      @(negedge clk);
    end
    chk($sformatf("an_digit%0d", k), an, target);
    chk($sformatf("seg_digit%0d", k), a_to_g, exp_seg);
  endtask

  // OR of all anodes driven low over n cycles.
  task automatic observe(input int n, input logic [7:0] exp_seen, input string name);
    logic [7:0] seen;
    seen = 8'h00;
    repeat (n) begin
      seen |= ~an;
      @(negedge clk);
    end
    chk(name, seen, exp_seen);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] q;
    logic [31:0] exp_idx;
    logic [7:0]  exp_an;

    //          w     addr   wdata          has_exp exp
    tbl[0]  = '{1'b0, 2'd0, 32'h0,          1'b1, 32'h0000_0000};
    tbl[1]  = '{1'b0, 2'd1, 32'h0,          1'b1, 32'h0000_00FF};
    tbl[2]  = '{1'b0, 2'd2, 32'h0,          1'b1, 32'h0000_0000};
    tbl[3]  = '{1'b1, 2'd0, 32'h1234_5678,  1'b0, 32'h0};
    tbl[4]  = '{1'b0, 2'd0, 32'h0,          1'b1, 32'h1234_5678};
    tbl[5]  = '{1'b1, 2'd1, 32'hFFFF_FF05,  1'b0, 32'h0};
    tbl[6]  = '{1'b0, 2'd1, 32'h0,          1'b1, 32'h0000_0005};
    tbl[7]  = '{1'b1, 2'd2, 32'hFFFF_FFFF,  1'b0, 32'h0};
    tbl[8]  = '{1'b0, 2'd2, 32'h0,          1'b1, 32'h0000_0001};
    tbl[9]  = '{1'b1, 2'd2, 32'h0,          1'b0, 32'h0};
    tbl[10] = '{1'b0, 2'd2, 32'h0,          1'b1, 32'h0000_0000};
    tbl[11] = '{1'b1, 2'd1, 32'h0000_00FF,  1'b0, 32'h0};
    tbl[12] = '{1'b1, 2'd0, 32'h0,          1'b0, 32'h0};
    tbl[13] = '{1'b1, 2'd2, 32'h0000_0002,  1'b0, 32'h0};
    tbl[14] = '{1'b0, 2'd0, 32'h0,          1'b1, 32'h0000_0000};
    tbl[15] = '{1'b0, 2'd1, 32'h0,          1'b1, 32'h0000_00FF};

    // Asynchronous reset, no clock edge yet.
    #1 rst = 1'b0;
    #2;
    chk("rst_an", an, 8'hFF);
    chk("rst_seg", a_to_g, 7'h7F);
    chk("rst_ready", ready, 1'b0);
    chk("rst_rdata", rdata, 32'd0);
    repeat (2) @(negedge clk);
    chk("rst_hold_an", an, 8'hFF);
    rst = 1'b1;

    // Scan after release: 4 cycles per digit, back to digit 0 after 32.
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      exp_an = ~(8'd1 << (((n - 1) / 4) % 8));
      chk($sformatf("scan_an_c%0d", n), an, exp_an);
      if (n == 1 || n == 33) chk("scan_seg0", a_to_g, 7'b0000001);
    end

    // STATUS tracks idx; a STATUS write must not disturb it.
    for (int r = 0; r < 4; r++) begin
      exp_idx = (edges / 4) % 8;
      bus(1'b0, 2'd3, 32'h0, q);
      chk("status_idx", q, exp_idx);
      if (r == 0) bus(1'b1, 2'd3, 32'h0000_0007, q);
      repeat (3) @(negedge clk);
    end

    // Register map.
    for (int i = 0; i < 16; i++) begin
      bus(tbl[i].w, tbl[i].a, tbl[i].d, q);
      if (tbl[i].has_exp) chk($sformatf("tbl%0d", i), q, tbl[i].exp);
    end

    // VALUE write mid-frame: digits stay 0 until the frame boundary.
    wait_phase(10);
    bus(1'b1, 2'd0, 32'h8765_43A1, q);
    for (int i = 0; i < 32; i++) begin
      if ((edges % 32) == 0) break;
      chk("old_frame_seg", a_to_g, 7'b0000001);
      @(negedge clk);
    end
    chk("old_frame_last", a_to_g, 7'b0000001);
    wait_digit(0, 7'b1001111);
    wait_digit(1, 7'b0001000);
    wait_digit(2, 7'b0000110);
    wait_digit(7, 7'b0000000);

    // MASK plus FORCE_LOAD: shadow mask takes effect mid-frame.
    bus(1'b1, 2'd1, 32'h0000_0005, q);
    bus(1'b0, 2'd1, 32'h0, q);
    chk("mask_rb", q, 32'h0000_0005);
    wait_phase(2);
    bus(1'b1, 2'd2, 32'h0000_0002, q);
    observe(40, 8'h05, "mask05_seen");
    bus(1'b1, 2'd1, 32'h0000_00FF, q);
    bus(1'b1, 2'd2, 32'h0000_0002, q);

    // BLANK on then off, both immediate.
    bus(1'b1, 2'd2, 32'h0000_0001, q);
    chk("blank_an", an, 8'hFF);
    observe(40, 8'h00, "blank_seen");
    bus(1'b1, 2'd2, 32'h0000_0000, q);
    exp_an = ~(8'd1 << (((edges - 1) / 4) % 8));
    chk("unblank_an", an, exp_an);

    // VALUE write on the frame-boundary edge: old value for one more frame.
    wait_phase(31);
    bus(1'b1, 2'd0, 32'h2222_2222, q);
    chk("wrap_an", an, 8'hFE);
    chk("wrap_seg_old", a_to_g, 7'b1001111);
    wait_digit(7, 7'b0000000);
    wait_digit(0, 7'b0010010);
    wait_digit(7, 7'b0010010);

    // Reset between edges while a read is in flight.
    sel = 1'b1; we = 1'b0; addr = 2'd0;
    @(posedge clk);
    #1;
    chk("pre_rst_ready", ready, 1'b1);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_an", an, 8'hFF);
    chk("mid_rst_seg", a_to_g, 7'h7F);
    chk("mid_rst_ready", ready, 1'b0);
    chk("mid_rst_rdata", rdata, 32'd0);
    sel = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bus(1'b0, 2'd0, 32'h0, q);
    chk("post_rst_value", q, 32'd0);
    bus(1'b0, 2'd1, 32'h0, q);
    chk("post_rst_mask", q, 32'h0000_00FF);

    // Leading digits.
    bus(1'b1, 2'd0, 32'h0000_00F0, q);
    bus(1'b1, 2'd2, 32'h0000_0002, q);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    observe(40, 8'h03, "lz_f0_seen");
`else
    observe(40, 8'hFF, "lz_f0_seen");
`endif
    wait_digit(1, 7'b0111000);
    wait_digit(0, 7'b0000001);
    bus(1'b1, 2'd0, 32'h0, q);
    bus(1'b1, 2'd2, 32'h0000_0002, q);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    observe(40, 8'h01, "lz_zero_seen");
`else
    observe(40, 8'hFF, "lz_zero_seen");
`endif
    wait_digit(0, 7'b0000001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Memory-mapped seven-segment display controller inside the soc, on the core's peripheral bus. It drives the top-level an and a_to_g pins.
- Holds a 32-bit value as eight hex nibbles.
- Time-multiplexes the nibbles onto the digits using a refresh prescaler.
- Double-buffers the value so a digit frame never shows a torn update.

Parameters:
REFRESH_DIV, 100000, clk cycles per digit slot; legal range >=2
NUM_DIGITS, 8, number of digits scanned; legal range 1..8; anodes at or above NUM_DIGITS are held 1

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
sel  input  1  bus request; master holds it until ready
we  input  1  1 = write, 0 = read; qualified by sel
addr  input  2  word offset: 0 VALUE, 1 MASK, 2 CTRL, 3 STATUS
wdata  input  32  write data
rdata  output  32  read data; valid while ready=1
ready  output  1  one-cycle completion pulse
an  output  8  digit anodes, active-low
a_to_g  output  7  segments {a,b,c,d,e,f,g}, active-low

Behaviour:
- Reset (rst=0, takes effect immediately, no clock needed):
  - value_reg=0, mask_reg=8'hFF, ctrl.BLANK=0.
  - shadow_val=0, shadow_mask=8'hFF.
  - presc=0, idx=0.
  - Outputs: an=8'hFF, a_to_g=7'h7F, ready=0, rdata=0.
- Reset asserted mid-operation: the same values apply at once, and any pending bus transaction is dropped.
- Bus handshake:
  - A transaction is accepted at a clk edge where sel=1 and ready=0.
  - ready=1 in the following cycle for exactly one cycle.
  - Writes update their register at the accepting edge.
  - rdata is registered at the accepting edge and is 0 whenever ready=0.
  - If sel is still high when ready drops, a new transaction is accepted on that edge.
- Register map:
  - VALUE (RW): 32 bits; nibble k is digit k.
  - MASK (RW): bits [7:0] enable digits; bits [31:8] read 0.
  - CTRL: bit0 BLANK (RW). bit1 FORCE_LOAD is write-1-to-act, self-clearing, and reads 0.
  - STATUS (RO): bits [2:0] = idx; other bits 0. Writes to STATUS are ignored.
- Prescaler and digit index:
  - presc counts 0..REFRESH_DIV-1; tick = (presc==REFRESH_DIV-1); presc wraps to 0 on tick.
  - On tick, idx advances, wrapping from NUM_DIGITS-1 to 0.
- Shadow load:
  - Happens on a tick where idx wraps to 0 (frame boundary), or at the accepting edge of a CTRL write with bit1=1.
  - Loads shadow_val<=value_reg and shadow_mask<=mask_reg.
  - The pre-write value_reg is used, so a VALUE write on the same edge as a load appears one frame later.
  - FORCE_LOAD and a frame boundary on the same edge give one load with identical result.
- Outputs, registered every cycle (one-cycle lag from idx):
  - an <= ~(onehot(idx) & shadow_mask & {8{~BLANK}}).
  - a_to_g <= decode(shadow_val[4*idx+:4]).
  - BLANK is not shadowed; it forces an=8'hFF on the next cycle.
  - a_to_g keeps decoding while blanked.
- Decode (active-low {a..g}):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000

Optional Feature:
SEG7_LEADING_ZERO_BLANK_EN
- Defined: digit k with shadow nibble 0 is forced off (its anode bit = 1) when all higher nibbles up to NUM_DIGITS-1 are also 0. Digit 0 is never suppressed, so value 0 shows a single "0".
- Undefined: all masked-in digits display, including leading zeros.

Test Plan:
- Reset release with REFRESH_DIV=4, NUM_DIGITS=8 -> first clk edge gives an=8'hFE, a_to_g=7'b0000001; anode low bit steps FE->FD->FB every 4 cycles; returns to FE after 32 cycles; STATUS reads track idx.
- Write VALUE=32'h8765_43A1 mid-frame -> digits keep showing 0 until the next frame boundary; then digit0=1001111, digit1=0001000 (A), digit7=0000000; ready pulses exactly 1 cycle after each sel.
- Write MASK=8'h05, then CTRL=32'h2 -> shadow loads immediately; only an=FE and an=FB are ever driven low; other slots show an=FF; MASK reads back 32'h05.
- Write CTRL=1 (BLANK) -> an=8'hFF from the cycle after ready; write CTRL=0 -> scanning resumes on the next cycle without waiting for a frame boundary.
- VALUE write on the same edge as the idx 7->0 wrap -> frame N shows the old value; frame N+1 shows the new value.
- Assert rst low between clk edges mid-transaction -> an=FF, a_to_g=7F, ready=0 immediately; a transaction issued after release completes normally.
- With SEG7_LEADING_ZERO_BLANK_EN, VALUE=32'h0000_00F0 -> only digits 0 and 1 light; VALUE=0 -> only digit 0 shows "0".
